// File: rtl/sva_seq_stim_gen_if.sv
// Handshake and stimulus bundle for sva_seq_stim_gen.
// Master issues requests; slave drives a/b and expected verdicts.
interface sva_seq_stim_gen_if #(
  parameter int LEN_WIDTH = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic [LEN_WIDTH-1:0] len;
  logic [1:0]           kind;
  logic                 ready;
  logic                 busy;
  logic                 a;
  logic                 b;
  logic                 done;
  logic                 exp_succ;
  logic                 exp_fail;
  logic [CNT_WIDTH-1:0] txn_cnt;

  modport master (
    output start, len, kind,
    input  ready, busy, a, b, done,
    input  exp_succ, exp_fail, txn_cnt
  );

  modport slave (
    input  start, len, kind,
    output ready, busy, a, b, done,
    output exp_succ, exp_fail, txn_cnt
  );
endinterface

// File: rtl/sva_seq_stim_gen.sv
// Stimulus driver for "(!a && !b)[*0:$] ##1 b" checkers.
// Optional self-start LFSR enabled by defining STIM_LFSR_EN.
module sva_seq_stim_gen #(
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic gclk,
  input  logic grst,
`ifdef STIM_LFSR_EN
  input  logic auto_en,
`endif
  sva_seq_stim_gen_if.slave s
);

  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    TERM,
    GAP
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           kind_q, kind_d;
  logic [GW-1:0]        gcnt_q, gcnt_d;
  logic                 a_q, a_d;
  logic                 b_q, b_d;
  logic                 done_q, done_d;
  logic                 succ_q, succ_d;
  logic                 fail_q, fail_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic [CNT_WIDTH-1:0] txn_q, txn_d;

  logic                 go;
  logic [LEN_WIDTH-1:0] go_len;
  logic [1:0]           go_kind;
  logic                 enter_term;
  logic [3:0]           tv;

  // Terminator pattern {a, b, succ, fail}; b wins when both are high.
  function automatic logic [3:0] term_vec(input logic [1:0] k);
    case (k)
      2'd0:    term_vec = 4'b0110;
      2'd1:    term_vec = 4'b1001;
      2'd2:    term_vec = 4'b1110;
      default: term_vec = 4'b0000;
    endcase
  endfunction

`ifdef STIM_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        fb;

  // Free-running Fibonacci LFSR, taps 16,14,13,11.
  always_comb begin
    fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d = {lfsr_q[14:0], fb};
  end

  // Request source: LFSR overrides external start when auto_en.
  always_comb begin
    go      = auto_en | s.start;
    go_len  = auto_en ? lfsr_q[LEN_WIDTH-1:0] : s.len;
    go_kind = auto_en ? lfsr_q[15:14] : s.kind;
  end

  // LFSR state, reseeded on reset.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) lfsr_q <= 16'hACE1;
    else      lfsr_q <= lfsr_d;
  end
`else
  // Request source: external start only.
  always_comb begin
    go      = s.start;
    go_len  = s.len;
    go_kind = s.kind;
  end
`endif

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kind_d     = kind_q;
    gcnt_d     = gcnt_q;
    enter_term = 1'b0;
    tv         = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          kind_d = go_kind;
          if (go_len != '0) begin
            state_d = HOLD;
            cnt_d   = go_len;
          end else begin
            state_d    = TERM;
            enter_term = 1'b1;
            tv         = term_vec(go_kind);
          end
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
          state_d    = TERM;
          enter_term = 1'b1;
          tv         = term_vec(kind_q);
        end
      end
      TERM: begin
        if (GAP_CYCLES > 0) begin
          state_d = GAP;
          gcnt_d  = GW'(GAP_CYCLES);
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        gcnt_d = gcnt_q - 1'b1;
        if (gcnt_q == {{(GW-1){1'b0}}, 1'b1}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    {a_d, b_d, succ_d, fail_d} = tv;
    done_d  = enter_term;
    txn_d   = txn_q + CNT_WIDTH'(enter_term);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kind_q  <= '0;
      gcnt_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      done_q  <= 1'b0;
      succ_q  <= 1'b0;
      fail_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      gcnt_q  <= gcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      succ_q  <= succ_d;
      fail_q  <= fail_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      txn_q   <= txn_d;
    end
  end

  assign s.ready    = ready_q;
  assign s.busy     = busy_q;
  assign s.a        = a_q;
  assign s.b        = b_q;
  assign s.done     = done_q;
  assign s.exp_succ = succ_q;
  assign s.exp_fail = fail_q;
  assign s.txn_cnt  = txn_q;

endmodule

// File: tb/tb_sva_seq_stim_gen.sv
// Directed bench for sva_seq_stim_gen.
// Second instance uses CNT_WIDTH=4, GAP_CYCLES=0.
module tb_sva_seq_stim_gen;

  logic gclk = 1'b0;
  logic grst = 1'b1;
  logic auto_en = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 gclk = ~gclk;

  sva_seq_stim_gen_if #(.LEN_WIDTH(8), .CNT_WIDTH(16)) bus ();
  sva_seq_stim_gen_if #(.LEN_WIDTH(8), .CNT_WIDTH(4))  bus4 ();

  sva_seq_stim_gen #(
    .LEN_WIDTH(8), .GAP_CYCLES(2), .CNT_WIDTH(16)
  ) dut (
    .gclk(gclk),
    .grst(grst),
`ifdef STIM_LFSR_EN
    .auto_en(auto_en),
`endif
    .s(bus)
  );

  sva_seq_stim_gen #(
    .LEN_WIDTH(8), .GAP_CYCLES(0), .CNT_WIDTH(4)
  ) dut4 (
    .gclk(gclk),
    .grst(grst),
`ifdef STIM_LFSR_EN
    .auto_en(1'b0),
`endif
    .s(bus4)
  );

  // {ready, busy, a, b, done, exp_succ, exp_fail}
  logic [6:0] obs, obs4;
  assign obs = {bus.ready, bus.busy, bus.a, bus.b,
                bus.done, bus.exp_succ, bus.exp_fail};
  assign obs4 = {bus4.ready, bus4.busy, bus4.a, bus4.b,
                 bus4.done, bus4.exp_succ, bus4.exp_fail};

  localparam logic [6:0] O_IDLE = 7'b1000000;
  localparam logic [6:0] O_BUSY = 7'b0100000;
  localparam logic [6:0] O_K0   = 7'b0101110;
  localparam logic [6:0] O_K1   = 7'b0110101;
  localparam logic [6:0] O_K2   = 7'b0111110;
  localparam logic [6:0] O_K3   = 7'b0100100;

  // Behavioural checker input stage: a/b registered once more.
  logic ca, cb;
  always @(posedge gclk) begin
    ca <= bus.a;
    cb <= bus.b;
  end

  task automatic issue(input logic [7:0] l, input logic [1:0] k);
    @(negedge gclk);
    bus.start = 1'b1;
    bus.len   = l;
    bus.kind  = k;
    @(posedge gclk);
    @(negedge gclk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    grst = 1'b1;
    bus.start = 0; bus.len = 0; bus.kind = 0;
    bus4.start = 0; bus4.len = 0; bus4.kind = 0;
    repeat (2) @(negedge gclk);
    n_chk++;
    if (obs !== O_IDLE) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want %b", obs, O_IDLE);
    end
    n_chk++;
    if (bus.txn_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", bus.txn_cnt);
    end
    grst = 1'b0;
    @(negedge gclk);
    n_chk++;
    if (obs !== O_IDLE) begin
      n_fail++;
      $display("FAIL post_reset: got %b want %b", obs, O_IDLE);
    end
  endtask

  task automatic test_succ_b_only();
    issue(8'd3, 2'd0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs !== O_BUSY) begin
        n_fail++;
        $display("FAIL k0_hold%0d: got %b want %b", i, obs, O_BUSY);
      end
      @(negedge gclk);
    end
    n_chk++;
    if (obs !== O_K0) begin
      n_fail++;
      $display("FAIL k0_term: got %b want %b", obs, O_K0);
    end
    n_chk++;
    if (bus.txn_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL k0_cnt: got %0d want 1", bus.txn_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge gclk);
      n_chk++;
      if (obs !== O_BUSY) begin
        n_fail++;
        $display("FAIL k0_gap%0d: got %b want %b", i, obs, O_BUSY);
      end
    end
    @(negedge gclk);
    n_chk++;
    if (obs !== O_IDLE || bus.txn_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL k0_ready: got %b/%0d want %b/1",
               obs, bus.txn_cnt, O_IDLE);
    end
  endtask

  task automatic test_fail_len0();
    issue(8'd0, 2'd1);
    n_chk++;
    if (obs !== O_K1) begin
      n_fail++;
      $display("FAIL k1_term: got %b want %b", obs, O_K1);
    end
    n_chk++;
    if (bus.txn_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL k1_cnt: got %0d want 2", bus.txn_cnt);
    end
    @(negedge gclk);
    n_chk++;
    if ({ca, cb} !== 2'b10) begin
      n_fail++;
      $display("FAIL k1_chk_delay: got %b want 10", {ca, cb});
    end
    repeat (2) @(negedge gclk);
    n_chk++;
    if (obs !== O_IDLE) begin
      n_fail++;
      $display("FAIL k1_ready: got %b want %b", obs, O_IDLE);
    end
  endtask

  task automatic test_both_succ();
    issue(8'd5, 2'd2);
    repeat (4) @(negedge gclk);
    n_chk++;
    if (obs !== O_BUSY) begin
      n_fail++;
      $display("FAIL k2_last_hold: got %b want %b", obs, O_BUSY);
    end
    @(negedge gclk);
    n_chk++;
    if (obs !== O_K2 || bus.txn_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL k2_term: got %b/%0d want %b/3",
               obs, bus.txn_cnt, O_K2);
    end
    repeat (3) @(negedge gclk);
  endtask

  task automatic test_back_to_back();
    logic [6:0] want;
    @(negedge gclk);
    bus.start = 1'b1;
    bus.len   = 8'd1;
    bus.kind  = 2'd3;
    for (int i = 0; i < 20; i++) begin
      @(posedge gclk);
      @(negedge gclk);
      want = (i % 5 == 1) ? O_K3 : O_BUSY;
      if (i % 5 == 4) want = O_IDLE;
      n_chk++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL b2b_cyc%0d: got %b want %b", i, obs, want);
      end
    end
    bus.start = 1'b0;
    @(negedge gclk);
    n_chk++;
    if (obs !== O_IDLE || bus.txn_cnt !== 16'd7) begin
      n_fail++;
      $display("FAIL b2b_end: got %b/%0d want %b/7",
               obs, bus.txn_cnt, O_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    issue(8'd200, 2'd0);
    repeat (10) @(negedge gclk);
    grst = 1'b1;
    #1;
    n_chk++;
    if (obs !== O_IDLE || bus.txn_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst: got %b/%0d want %b/0",
               obs, bus.txn_cnt, O_IDLE);
    end
    @(negedge gclk);
    grst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge gclk);
      n_chk++;
      if (obs !== O_IDLE) begin
        n_fail++;
        $display("FAIL midrst_idle%0d: got %b want %b",
                 i, obs, O_IDLE);
      end
    end
  endtask

  task automatic test_wrap_gap0();
    for (int t = 1; t <= 17; t++) begin
      @(negedge gclk);
      bus4.start = 1'b1;
      bus4.len   = 8'd0;
      bus4.kind  = 2'd0;
      @(posedge gclk);
      @(negedge gclk);
      bus4.start = 1'b0;
      n_chk++;
      if (obs4 !== O_K0 || bus4.txn_cnt !== 4'(t)) begin
        n_fail++;
        $display("FAIL wrap_t%0d: got %b/%0d want %b/%0d",
                 t, obs4, bus4.txn_cnt, O_K0, t % 16);
      end
      @(negedge gclk);
      if (t == 17) begin
        n_chk++;
        if (obs4 !== O_IDLE || bus4.txn_cnt !== 4'd1) begin
          n_fail++;
          $display("FAIL wrap_end: got %b/%0d want %b/1",
                   obs4, bus4.txn_cnt, O_IDLE);
        end
      end
    end
  endtask

`ifdef STIM_LFSR_EN
  task automatic test_lfsr();
    int seen;
    @(negedge gclk);
    grst = 1'b1;
    auto_en = 1'b1;
    @(negedge gclk);
    grst = 1'b0;
    @(posedge gclk);
    @(negedge gclk);
    auto_en = 1'b0;
    seen = -1;
    for (int i = 1; i < 400 && seen < 0; i++) begin
      @(negedge gclk);
      if (bus.done === 1'b1) seen = i;
    end
    n_chk++;
    if (seen != 225 || obs !== O_K2) begin
      n_fail++;
      $display("FAIL lfsr_first: got %0d/%b want 225/%b",
               seen, obs, O_K2);
    end
    repeat (4) @(negedge gclk);
  endtask
`endif

  initial begin
    test_reset();
    test_succ_b_only();
    test_fail_len0();
    test_both_succ();
    test_back_to_back();
    test_reset_mid();
    test_wrap_gap0();
`ifdef STIM_LFSR_EN
    test_lfsr();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sva_seq_stim_gen.md
Name: sva_seq_stim_gen

Overview:
Transaction-level stimulus driver for the gclk-domain property checkers in this directory. Each transaction holds a=0, b=0 for a programmed number of cycles, then drives one terminating pattern. It also raises the verdict (succ/fail) that a checker for "(!a && !b)[*0:$] ##1 b" must report for the thread that observes the terminator. The block sits on the transmit side of the checker, drives its a/b inputs, and feeds the expected verdicts to the bench scoreboard.

Parameters:
LEN_WIDTH, 8, width of the hold-length field; max hold = 2^LEN_WIDTH-1 cycles.
GAP_CYCLES, 2, idle cycles (a=0, b=0) inserted after each terminator before ready returns; 0 allowed.
CNT_WIDTH, 16, width of the completed-transaction counter.

Ports:
gclk  in  1  user clock; all logic on posedge.
grst  in  1  reset, asynchronous, active-high.
start  in  1  request; accepted when start && ready at posedge gclk.
len  in  LEN_WIDTH  number of a=0/b=0 hold cycles before the terminator.
kind  in  2  terminator: 0=B_ONLY, 1=A_ONLY, 2=A_AND_B, 3=NONE.
ready  out  1  high only in IDLE.
busy  out  1  high in HOLD, TERM and GAP.
a  out  1  driven stimulus a, registered.
b  out  1  driven stimulus b, registered.
done  out  1  one-cycle pulse coincident with the TERM cycle.
exp_succ  out  1  pulse with done when kind is 0 or 2.
exp_fail  out  1  pulse with done when kind is 1.
txn_cnt  out  CNT_WIDTH  count of done pulses.

Behaviour:
- Reset (grst high, async): state=IDLE, a=b=0, done=exp_succ=exp_fail=0, txn_cnt=0, ready=1, busy=0. Deassertion is synchronous to gclk by the integrator. Reset mid-transaction abandons it without a done pulse.
- All outputs are registered. No combinational path from start/len/kind to any output.
- FSM: IDLE, HOLD, TERM, GAP.
- IDLE: a=b=0. On start && ready, capture len and kind.
  - If len>0, go to HOLD with cnt=len.
  - If len=0, go directly to TERM.
  - start while not ready is ignored; no queueing.
- HOLD: a=b=0 for exactly len cycles. cnt decrements each cycle; on cnt==1, go to TERM.
- TERM: exactly one cycle.
  - kind 0: a=0, b=1.
  - kind 1: a=1, b=0.
  - kind 2: a=1, b=1. b takes priority in the checker, so the verdict is succ.
  - kind 3: a=0, b=0, and neither exp flag is raised.
  - done=1 for all kinds; txn_cnt increments. txn_cnt wraps from all-ones to 0.
  - Next state: GAP if GAP_CYCLES>0, else IDLE.
- GAP: a=b=0 for GAP_CYCLES cycles, then IDLE.
- Latency: start sampled at edge k gives the first HOLD value on a/b after edge k+1. The TERM cycle follows len cycles later.
  - The checker registers a/b once more (a_delay/b_delay), so its succ/fail is one gclk after exp_* plus sys_clk evaluation time. The scoreboard aligns by +1 gclk.
- Back-to-back transactions: the minimum spacing between TERM cycles is len+1+GAP_CYCLES+1 gclk.

Optional Feature:
STIM_LFSR_EN.
- Defined: adds input port auto_en (1 bit) and a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) that advances every gclk.
  - In IDLE with auto_en=1, the block self-starts with len=lfsr[LEN_WIDTH-1:0] and kind=lfsr[15:14]. The external start is ignored while auto_en=1.
- Not defined: auto_en and the LFSR do not exist; transactions start only from start.

Test Plan:
- Reset, then start with len=3, kind=0 -> a=b=0 for 3 cycles; TERM a=0,b=1 with done=exp_succ=1; 2 GAP cycles; ready back high; txn_cnt=1.
- len=0, kind=1 -> TERM on the cycle after acceptance with a=1,b=0, exp_fail=1, exp_succ=0; the checker's fail follows 1 gclk later.
- len=5, kind=2 -> TERM a=1,b=1 with exp_succ=1, matching the checker succ (b priority).
- start held high continuously with len=1, kind=3 -> transaction every 1+1+1+2=5 cycles; done pulses; exp_succ=exp_fail=0; starts during busy are ignored.
- grst asserted during HOLD of a len=200 transaction -> a=b=0, no done, txn_cnt=0, ready=1 immediately.
- CNT_WIDTH=4, 17 transactions -> txn_cnt wraps to 1; with STIM_LFSR_EN and auto_en=1, the first auto transaction uses len=8'hE1, kind=2'b10.
